pc_gen: RTL

- Parametrised fetch-address generator; replaces the single-source PC register at the head of the IF stage.
- Holds the fetch PC and advances it by one aligned fetch block per accepted cycle.
- Arbitrates NUM_REDIRECT prioritised redirect sources (exception, branch mispredict, predictor, ...).
- Supports a low-power SLEEP state for the MIPS WAIT instruction.
- Drives the IF stage with the PC, a valid flag and a per-slot valid mask.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_gen_redir_arb.sv | 35 +++
 rtl/pc_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-address generator.
// Revision 1.0
`default_nettype none

package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    SLEEP = 2'd2
  } pc_gen_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  localparam int REDIR_EXC = 0;
  localparam int REDIR_BR  = 1;
  localparam int REDIR_BP  = 2;

endpackage

`default_nettype wire

// File: rtl/pc_gen_redir_arb.sv
// redir_arb: fixed-priority one-hot arbiter (index 0 wins) with target mux.
// Revision 1.0
`default_nettype none

module redir_arb #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
) (
  input  logic [NUM_REQ-1:0]        i_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_any
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_data  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_valid[k] && !w_found) begin
        o_grant[k] = 1'b1;
        o_data     = i_data[k*DATA_W +: DATA_W];
        w_found    = 1'b1;
      end
    end
  end

  assign o_any = |i_valid;

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with prioritised redirects and a WAIT sleep state.
// Optional macro PC_GEN_ALIGN_EXC_EN adds adel_o/badvaddr_o. Revision 1.0
`default_nettype none

module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                FETCH_WIDTH  = 2,
  parameter int                NUM_REDIRECT = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           stall_i,
  input  logic                           wait_i,
  input  logic [NUM_REDIRECT-1:0]        redir_valid_i,
  input  logic [NUM_REDIRECT*ADDR_W-1:0] redir_pc_i,
  output logic [ADDR_W-1:0]              pc_o,
  output logic                           pc_valid_o,
  output logic [FETCH_WIDTH-1:0]         slot_mask_o,
  output logic [ADDR_W-1:0]              npc_o,
  output logic [NUM_REDIRECT-1:0]        redir_grant_o
`ifdef PC_GEN_ALIGN_EXC_EN
  ,
  output logic                           adel_o,
  output logic [ADDR_W-1:0]              badvaddr_o
`endif
);

  localparam int                BLK         = FETCH_WIDTH * 4;
  localparam int                OFF_W       = $clog2(BLK);
  localparam logic [ADDR_W-1:0] c_blk       = ADDR_W'(BLK);
  localparam logic [ADDR_W-1:0] c_blk_mask  = ~(ADDR_W'(BLK - 1));
  localparam logic [ADDR_W-1:0] c_word_mask = ~(ADDR_W'(3));

  pc_gen_state_e               r_state;
  logic [ADDR_W-1:0]           r_pc;
  logic                        r_pc_valid;
  logic [ADDR_W-1:0]           w_npc;
  logic [ADDR_W-1:0]           w_seq_pc;
  logic [ADDR_W-1:0]           w_tgt_raw;
  logic [ADDR_W-1:0]           w_tgt;
  logic [NUM_REDIRECT-1:0]     w_grant;
  logic                        w_any;
  logic                        w_hold;
  logic                        w_show;

  redir_arb #(
    .NUM_REQ (NUM_REDIRECT),
    .DATA_W  (ADDR_W)
  ) u_arb (
    .i_valid (redir_valid_i),
    .i_data  (redir_pc_i),
    .o_grant (w_grant),
    .o_data  (w_tgt_raw),
    .o_any   (w_any)
  );

`ifdef PC_GEN_ALIGN_EXC_EN
  logic              r_adel;
  logic [ADDR_W-1:0] r_badvaddr;
  logic              w_misalign;

  assign w_tgt      = w_tgt_raw;
  assign w_misalign = |w_tgt_raw[1:0];
  // A misaligned PC is parked until software redirects away from it.
  assign w_hold     = r_adel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_adel     <= 1'b0;
      r_badvaddr <= '0;
    end else if (w_any) begin
      r_adel     <= w_misalign;
      r_badvaddr <= w_misalign ? w_tgt : '0;
    end
  end

  assign adel_o     = r_adel;
  assign badvaddr_o = r_badvaddr;
`else
  assign w_tgt  = w_tgt_raw & c_word_mask;
  assign w_hold = 1'b0;
`endif

  assign w_seq_pc = (r_pc & c_blk_mask) + c_blk;

  // WAIT holds the PC in the same cycle it moves the FSM to SLEEP.
  always_comb begin
    w_npc = r_pc;
    if (w_any) begin
      w_npc = w_tgt;
    end else if (r_state == RUN && !stall_i && !wait_i && !w_hold) begin
      w_npc = w_seq_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
    end else begin
      r_pc <= w_npc;
      unique case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        RUN: begin
          if (!w_any && wait_i) begin
            r_state    <= SLEEP;
            r_pc_valid <= 1'b0;
          end else begin
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
          end
        end
        SLEEP: begin
          if (w_any) begin
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_show = r_pc_valid & ~w_hold;

  generate
    if (FETCH_WIDTH == 1) begin : g_fw1
      assign slot_mask_o = w_show;
    end else begin : g_fwn
      localparam int SLOT_W = OFF_W - 2;
      logic [SLOT_W-1:0] w_slot;
      assign w_slot = r_pc[OFF_W-1:2];
      for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        assign slot_mask_o[i] = w_show & (w_slot <= SLOT_W'(i));
      end
    end
  endgenerate

  assign pc_o          = r_pc;
  assign pc_valid_o    = r_pc_valid;
  assign npc_o         = w_npc;
  assign redir_grant_o = rst_ni ? w_grant : '0;

endmodule

`default_nettype wire
